// File: rtl/item_checker.sv
// Sequence-checking elastic buffer: stores items in FIFO order and flags any item
// that is not the previous accepted item + 1 (mod 2^WIDTH).
// Latency: 1 cycle from accept edge to out_item/out_valid; no same-cycle bypass.
// Backpressure: in_ready drops when DEPTH items are held; refused items are not checked.
//
// Ports:
//   clk, reset (async, active-low)
//   in_item/in_valid/in_ready       : upstream valid-ready handshake
//   out_item/out_valid/out_ready    : downstream valid-ready handshake (head of buffer)
//   count                           : current occupancy, 0..DEPTH
//   locked                          : checker holds a reference value
//   err                             : one-cycle pulse after an out-of-sequence accept
//   err_count                       : saturating number of sequence errors

// Generic register-based FIFO.
// Latency: 1 cycle write-to-read; both ready and valid come from registers only.
// Backpressure: wr_rdy_o low when full; rd_rdy_i ignored when empty.
module item_checker_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_vld_i,
  output logic                     wr_rdy_o,
  input  logic [WIDTH-1:0]         wr_dat_i,
  output logic                     rd_vld_o,
  input  logic                     rd_rdy_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign wr_rdy_o = (cnt_q != CW'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign push     = wr_vld_i & wr_rdy_o;
  assign pop      = rd_vld_o & rd_rdy_i;
  assign count_o  = cnt_q;

  // Storage is not reset; the head is forced to zero whenever the buffer is
  // empty so reset and drained states both present out_item = 0.
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

  // DEPTH is a power of two, so natural AW-bit overflow gives modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

// Top: FIFO data path plus a two-state sequence checker snooping accepted items.
// Latency: 1 cycle through the buffer; err is registered on the accepting edge.
// Backpressure: in_ready = not full; checking never stalls or alters data.
module item_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_item,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_item,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   locked,
  output logic                   err,
  output logic [15:0]            err_count
);
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             err_q, err_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             push;

  item_checker_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_vld_i (in_valid),
    .wr_rdy_o (in_ready),
    .wr_dat_i (in_item),
    .rd_vld_o (out_valid),
    .rd_rdy_i (out_ready),
    .rd_dat_o (out_item),
    .count_o  (count)
  );

  // Only accepted items are checked; anything refused while full is invisible.
  assign push = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    if (push) begin
      // Every accepted item (first, in-sequence or not) re-seeds the reference,
      // so a single glitch costs one error rather than a cascade.
      expected_d = in_item + WIDTH'(1);
      case (state_q)
        UNLOCKED: state_d = LOCKED;
        LOCKED: begin
          if (in_item != expected_q) begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      expected_q  <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_item_checker.sv
module tb_item_checker;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_item;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_item;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             locked;
  logic             err;
  logic [15:0]      err_count;

  int errors = 0;
  int checks = 0;

  item_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_item   (in_item),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_item  (out_item),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return 1 time unit after it.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_item   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; release well before the next rising edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  typedef struct {
    bit               rst;
    bit               vld;
    logic [WIDTH-1:0] item;
    bit               ordy;
    bit               e_vld;
    logic [WIDTH-1:0] e_item;
    logic [2:0]       e_cnt;
    bit               e_inrdy;
    bit               e_err;
    bit               e_lock;
    logic [15:0]      e_ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit vld, logic [7:0] item, bit ordy,
                              bit e_vld, logic [7:0] e_item, logic [2:0] e_cnt,
                              bit e_inrdy, bit e_err, bit e_lock, logic [15:0] e_ecnt);
    vec_t v;
    v = '{rst, vld, item, ordy, e_vld, e_item, e_cnt, e_inrdy, e_err, e_lock, e_ecnt};
    tbl.push_back(v);
  endfunction

  // Reference model state, kept at transaction level.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_exp;
  bit               m_lock;
  bit               m_err;
  int               m_ecnt;

  initial begin
    int unsigned nrand;
    logic [WIDTH-1:0] d;
    bit v, r, push, pop;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_item   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst count", 32'(count), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_item", 32'(out_item), 0);
    chk("rst err", 32'(err), 0);
    chk("rst err_count", 32'(err_count), 0);
    chk("rst locked", 32'(locked), 0);
    #2 reset = 1'b1;

    // In-order stream 0..19, out_ready=1: each item visible right after its accept edge.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, WIDTH'(i), 1'b1);
      chk($sformatf("stream%0d out_item", i), 32'(out_item), 32'(i));
      chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("stream%0d count", i), 32'(count), 1);
      chk($sformatf("stream%0d err", i), 32'(err), 0);
      chk($sformatf("stream%0d locked", i), 32'(locked), 1);
    end
    step(1'b0, '0, 1'b1);
    chk("stream drain count", 32'(count), 0);
    chk("stream err_count", 32'(err_count), 0);

    // Fill/backpressure: 14 refused when full and not checked (push 14 later is fine).
    add(1,1,10,0, 1,10,1,1,0,1,0);
    add(0,1,11,0, 1,10,2,1,0,1,0);
    add(0,1,12,0, 1,10,3,1,0,1,0);
    add(0,1,13,0, 1,10,4,0,0,1,0);
    add(0,1,14,0, 1,10,4,0,0,1,0);
    add(0,0, 0,1, 1,11,3,1,0,1,0);
    add(0,0, 0,1, 1,12,2,1,0,1,0);
    add(0,0, 0,1, 1,13,1,1,0,1,0);
    add(0,0, 0,1, 0, 0,0,1,0,1,0);
    add(0,1,14,0, 1,14,1,1,0,1,0);
    // Gap error: only 9 is an error.
    add(1,1, 5,1, 1, 5,1,1,0,1,0);
    add(0,1, 6,1, 1, 6,1,1,0,1,0);
    add(0,1, 9,1, 1, 9,1,1,1,1,1);
    add(0,1,10,1, 1,10,1,1,0,1,1);
    add(0,0, 0,1, 0, 0,0,1,0,1,1);
    // Wrap 254,255,0,1 in sequence; then 255,255 errors on the second.
    add(1,1,254,1, 1,254,1,1,0,1,0);
    add(0,1,255,1, 1,255,1,1,0,1,0);
    add(0,1,  0,1, 1,  0,1,1,0,1,0);
    add(0,1,  1,1, 1,  1,1,1,0,1,0);
    add(1,1,255,1, 1,255,1,1,0,1,0);
    add(0,1,255,1, 1,255,1,1,1,1,1);
    add(0,0,  0,1, 0,  0,0,1,0,1,1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].vld, tbl[i].item, tbl[i].ordy);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("vec%0d out_item", i), 32'(out_item), 32'(tbl[i].e_item));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_inrdy));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].e_lock));
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].e_ecnt));
    end

    // Reset mid-stream: three buffered items with two errors, reset between edges.
    do_reset();
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd9, 1'b0);
    step(1'b1, 8'd11, 1'b0);
    chk("mid pre count", 32'(count), 3);
    chk("mid pre err_count", 32'(err_count), 2);
    reset = 1'b0;
    #1;
    chk("mid async count", 32'(count), 0);
    chk("mid async out_valid", 32'(out_valid), 0);
    chk("mid async in_ready", 32'(in_ready), 1);
    chk("mid async out_item", 32'(out_item), 0);
    chk("mid async err", 32'(err), 0);
    chk("mid async err_count", 32'(err_count), 0);
    chk("mid async locked", 32'(locked), 0);
    #1 reset = 1'b1;
    step(1'b1, 8'd50, 1'b0);
    chk("mid post err", 32'(err), 0);
    chk("mid post locked", 32'(locked), 1);
    chk("mid post out_item", 32'(out_item), 50);
    chk("mid post count", 32'(count), 1);
    step(1'b0, '0, 1'b1);
    chk("mid post drained", 32'(out_valid), 0);

    // Full duplex at count=2.
    do_reset();
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b1);
    chk("duplex count", 32'(count), 2);
    chk("duplex out_item", 32'(out_item), 2);
    chk("duplex err", 32'(err), 0);

    // Saturation: 1 locking push then 65536 mismatches (all zeros).
    do_reset();
    for (int i = 0; i < 65535; i++) step(1'b1, 8'd0, 1'b1);
    chk("sat near err_count", 32'(err_count), 65534);
    step(1'b1, 8'd0, 1'b1);
    chk("sat at err_count", 32'(err_count), 65535);
    step(1'b1, 8'd0, 1'b1);
    chk("sat hold err_count", 32'(err_count), 65535);
    chk("sat err", 32'(err), 1);
    chk("sat locked", 32'(locked), 1);

    // Randomized traffic against the transaction-level model.
    do_reset();
    mq.delete();
    m_exp  = '0;
    m_lock = 1'b0;
    m_err  = 1'b0;
    m_ecnt = 0;
    nrand  = 3000;
    for (int n = 0; n < int'(nrand); n++) begin
      v = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 60) ? m_exp : WIDTH'($urandom);
      push = v && (mq.size() < DEPTH);
      pop  = r && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      m_err = 1'b0;
      if (push) begin
        if (m_lock && d != m_exp) begin
          m_err = 1'b1;
          if (m_ecnt < 65535) m_ecnt++;
        end
        m_exp  = d + WIDTH'(1);
        m_lock = 1'b1;
        mq.push_back(d);
      end
      step(v, d, r);
      chk($sformatf("rnd%0d count", n), 32'(count), 32'(mq.size()));
      chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(mq.size() != 0));
      chk($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(mq.size() != DEPTH));
      if (mq.size() != 0) chk($sformatf("rnd%0d out_item", n), 32'(out_item), 32'(mq[0]));
      chk($sformatf("rnd%0d err", n), 32'(err), 32'(m_err));
      chk($sformatf("rnd%0d locked", n), 32'(locked), 32'(m_lock));
      chk($sformatf("rnd%0d err_count", n), 32'(err_count), 32'(m_ecnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/item_checker.md
ITEM_CHECKER -- requirements
Module: item_checker

Interface
REQ-001 Parameter WIDTH, default 8, item width in bits.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_item  input  WIDTH  received item.
REQ-006 in_valid  input  1  in_item is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_item this cycle.
REQ-008 out_item  output  WIDTH  item at the buffer head.
REQ-009 out_valid  output  1  out_item is valid.
REQ-010 out_ready  input  1  downstream takes out_item this cycle.
REQ-011 count  output  clog2(DEPTH)+1  current buffer occupancy.
REQ-012 locked  output  1  sequence checker holds a reference value.
REQ-013 err  output  1  one-cycle pulse on a sequence error.
REQ-014 err_count  output  16  saturating count of sequence errors.

Function
REQ-015 The push condition SHALL be in_valid && in_ready; the pop condition SHALL be out_valid && out_ready.
REQ-016 in_ready SHALL equal (count != DEPTH), driven from registers only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0); out_item SHALL be the oldest stored item, registered with no combinational path from in_item.
REQ-018 Latency: an item pushed at edge N SHALL be visible on out_item/out_valid after edge N; there is no same-cycle bypass.
REQ-019 Buffer order SHALL be strictly FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-020 A simultaneous push and pop SHALL leave count unchanged; push-only SHALL add 1; pop-only SHALL subtract 1.
REQ-021 When full, in_valid SHALL be ignored and data SHALL be neither stored nor checked; when empty, out_ready SHALL be ignored.
REQ-022 The checker FSM SHALL have two states, UNLOCKED and LOCKED, and locked SHALL be 1 exactly in LOCKED.
REQ-023 In UNLOCKED, the first push SHALL load expected = in_item + 1 (mod 2^WIDTH) and move the FSM to LOCKED, with no error raised.
REQ-024 In LOCKED, on a push with in_item == expected, expected SHALL become in_item + 1 (mod 2^WIDTH).
REQ-025 In LOCKED, on a push with in_item != expected, the block SHALL do all of the following on the same edge:
- pulse err for one cycle;
- increment err_count;
- resync expected to in_item + 1;
- stay in LOCKED.
REQ-026 Wrap-around from 2^WIDTH-1 to 0 SHALL count as in sequence.
REQ-027 err_count SHALL saturate at 65535 and never wrap.
REQ-028 Erroneous items SHALL still be stored and forwarded; checking SHALL NOT affect the data path.
REQ-029 Cycles without a push SHALL NOT change expected or the FSM state.

Reset
REQ-030 Asserting reset (0) SHALL immediately set the following, regardless of clk:
- count = 0, pointers = 0, out_valid = 0, in_ready = 1;
- out_item = 0, err = 0, err_count = 0, expected = 0;
- FSM = UNLOCKED.
REQ-031 Reset asserted mid-operation SHALL discard all buffered items; none SHALL appear after release.
REQ-032 The first rising edge with reset = 1 SHALL be a normal operating edge.

Verification
REQ-033 Bench SHALL cover in-order stream: items 0..19 pushed one per cycle with out_ready=1 -> out_item 0..19 in order, one cycle behind the input, err never 1, err_count=0, locked=1 from item 0 onward.
REQ-034 Bench SHALL cover fill and backpressure: out_ready=0, push 10,11,12,13,14 -> in_ready=0 after the 4th push, count=4, item 14 not stored; then out_ready=1 -> outputs 10,11,12,13, then count=0.
REQ-035 Bench SHALL cover gap error: push 5,6,9,10 -> err pulses exactly once, on the edge that accepts 9; err_count=1; 10 is not an error; all four items are output.
REQ-036 Bench SHALL cover wrap: push 254,255,0,1 -> no err; push 255,255 -> the second 255 raises err and err_count increments.
REQ-037 Bench SHALL cover reset mid-stream: push 3 items with out_ready=0, then drive reset=0 between clock edges -> outputs clear at once; after release, push 50 -> no err, locked=1, out_item=50.
REQ-038 Bench SHALL cover saturation and full-duplex operation:
- force 65536 mismatching pushes -> err_count stays at 65535;
- at count=2, push and pop in the same cycle -> count stays 2.
